// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Purpose:
//   Shares one register file (two combinational read ports, one write port)
//   between two requesters. A request is accepted in IDLE, its operation is
//   presented to the register file for exactly one ACCESS cycle, and the
//   owning requester receives a one-cycle completion pulse in RESP.
//   One transaction completes every three cycles.
//
//   Selection is round-robin by default: a lone valid requester is always
//   granted, and a tie goes to the requester that was not granted last.
//   Defining REGFILE_ARB_FIXED_PRIO_EN switches to fixed priority, where
//   requester 0 always wins a tie and no last-grant history is kept.
//
//   Writes to index 0 complete normally (rsp_valid still pulses) but never
//   raise rf_write_enable, so register 0 stays constant.
//
// Parameters:
//   WIDTH  data width
//   DEPTH  index width (2**DEPTH registers)
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   req_valid[1:0]   per-requester request valid
//   req_write[1:0]   per-requester op (1 = write, 0 = read)
//   req_idx_a        per-requester read index 1 / write index, DEPTH bits each
//   req_idx_b        per-requester read index 2, DEPTH bits each
//   req_wdata        per-requester write data, WIDTH bits each
//   req_ready[1:0]   combinational accept strobe
//   rsp_valid[1:0]   one-cycle completion pulse for the granted requester
//   rsp_data_a/b     read data of the most recently completed read
//   rf_read_enable   drives both register-file read enables
//   rf_read_index_1/2, rf_read_data_1/2   register-file read ports
//   rf_write_enable, rf_write_index, rf_write_data   register-file write port
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [1:0]           req_write,
    input  logic [2*DEPTH-1:0]   req_idx_a,
    input  logic [2*DEPTH-1:0]   req_idx_b,
    input  logic [2*WIDTH-1:0]   req_wdata,
    output logic [1:0]           req_ready,
    output logic [1:0]           rsp_valid,
    output logic [WIDTH-1:0]     rsp_data_a,
    output logic [WIDTH-1:0]     rsp_data_b,
    output logic                 rf_read_enable,
    output logic [DEPTH-1:0]     rf_read_index_1,
    output logic [DEPTH-1:0]     rf_read_index_2,
    input  logic [WIDTH-1:0]     rf_read_data_1,
    input  logic [WIDTH-1:0]     rf_read_data_2,
    output logic                 rf_write_enable,
    output logic [DEPTH-1:0]     rf_write_index,
    output logic [WIDTH-1:0]     rf_write_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Transaction context captured on accept
    logic             grant_q, grant_d;
    logic             op_write_q, op_write_d;
    logic [DEPTH-1:0] idx_a_q, idx_a_d;
    logic [DEPTH-1:0] idx_b_q, idx_b_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    // Response data, held until the next read completes
    logic [WIDTH-1:0] rsp_data_a_q, rsp_data_a_d;
    logic [WIDTH-1:0] rsp_data_b_q, rsp_data_b_d;

`ifndef REGFILE_ARB_FIXED_PRIO_EN
    // Requester granted most recently; reset to 1 so requester 0 wins the first tie
    logic last_grant_q, last_grant_d;
`endif

    logic sel;     // requester chosen this cycle
    logic accept;  // a request is taken on the coming edge

    // -------------------------------------------------------------------------
    // Requester selection
    // -------------------------------------------------------------------------
    always_comb begin
        sel = 1'b0;
        case (req_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11: begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
                sel = 1'b0;
`else
                sel = ~last_grant_q;
`endif
            end
            default: sel = 1'b0;
        endcase
    end

    // Ready is only offered in IDLE; reset masks it immediately so nothing
    // can be taken while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == IDLE) && !reset && req_valid[sel]) begin
            req_ready[sel] = 1'b1;
        end
        accept = |req_ready;
    end

    // -------------------------------------------------------------------------
    // Next-state and context capture
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        op_write_d   = op_write_q;
        idx_a_d      = idx_a_q;
        idx_b_d      = idx_b_q;
        wdata_d      = wdata_q;
        rsp_data_a_d = rsp_data_a_q;
        rsp_data_b_d = rsp_data_b_q;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = ACCESS;
                    grant_d    = sel;
                    op_write_d = req_write[sel];
                    idx_a_d    = sel ? req_idx_a[DEPTH +: DEPTH] : req_idx_a[0 +: DEPTH];
                    idx_b_d    = sel ? req_idx_b[DEPTH +: DEPTH] : req_idx_b[0 +: DEPTH];
                    wdata_d    = sel ? req_wdata[WIDTH +: WIDTH] : req_wdata[0 +: WIDTH];
`ifndef REGFILE_ARB_FIXED_PRIO_EN
                    last_grant_d = sel;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Read data is combinational from the register file and is
                // captured on the edge that closes ACCESS.
                if (!op_write_q) begin
                    rsp_data_a_d = rf_read_data_1;
                    rsp_data_b_d = rf_read_data_2;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Register-file and response outputs (all zero outside ACCESS / RESP)
    // -------------------------------------------------------------------------
    always_comb begin
        rf_read_enable  = 1'b0;
        rf_read_index_1 = '0;
        rf_read_index_2 = '0;
        rf_write_enable = 1'b0;
        rf_write_index  = '0;
        rf_write_data   = '0;
        rsp_valid       = 2'b00;

        if (state_q == ACCESS) begin
            if (op_write_q) begin
                // Register 0 is constant: the write completes but is not issued.
                rf_write_enable = |idx_a_q;
                rf_write_index  = idx_a_q;
                rf_write_data   = wdata_q;
            end else begin
                rf_read_enable  = 1'b1;
                rf_read_index_1 = idx_a_q;
                rf_read_index_2 = idx_b_q;
            end
        end

        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

    assign rsp_data_a = rsp_data_a_q;
    assign rsp_data_b = rsp_data_b_q;

    // -------------------------------------------------------------------------
    // Control state: asynchronous reset drops any transaction in flight
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rsp_data_a_q <= rsp_data_a_d;
            rsp_data_b_q <= rsp_data_b_d;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Transaction payload: only consumed in ACCESS, so it needs no reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        op_write_q <= op_write_d;
        idx_a_q    <= idx_a_d;
        idx_b_q    <= idx_b_d;
        wdata_q    <= wdata_d;
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;

    logic               clk;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_write;
    logic [2*DEPTH-1:0] req_idx_a;
    logic [2*DEPTH-1:0] req_idx_b;
    logic [2*WIDTH-1:0] req_wdata;
    logic [1:0]         req_ready;
    logic [1:0]         rsp_valid;
    logic [WIDTH-1:0]   rsp_data_a;
    logic [WIDTH-1:0]   rsp_data_b;
    logic               rf_read_enable;
    logic [DEPTH-1:0]   rf_read_index_1;
    logic [DEPTH-1:0]   rf_read_index_2;
    logic [WIDTH-1:0]   rf_read_data_1;
    logic [WIDTH-1:0]   rf_read_data_2;
    logic               rf_write_enable;
    logic [DEPTH-1:0]   rf_write_index;
    logic [WIDTH-1:0]   rf_write_data;

    regfile_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_idx_a       (req_idx_a),
        .req_idx_b       (req_idx_b),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data_a      (rsp_data_a),
        .rsp_data_b      (rsp_data_b),
        .rf_read_enable  (rf_read_enable),
        .rf_read_index_1 (rf_read_index_1),
        .rf_read_index_2 (rf_read_index_2),
        .rf_read_data_1  (rf_read_data_1),
        .rf_read_data_2  (rf_read_data_2),
        .rf_write_enable (rf_write_enable),
        .rf_write_index  (rf_write_index),
        .rf_write_data   (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model attached to the DUT's rf ports
    logic [WIDTH-1:0] rf_mem [2**DEPTH];
    initial for (int i = 0; i < 2**DEPTH; i++) rf_mem[i] = '0;
    assign rf_read_data_1 = rf_mem[rf_read_index_1];
    assign rf_read_data_2 = rf_mem[rf_read_index_2];
    always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_index] <= rf_write_data;

    // Bench-side expectations
    logic [WIDTH-1:0] exp_mem [2**DEPTH];
    logic [WIDTH-1:0] last_a, last_b;

    typedef struct {
        int               r;
        bit               wr;
        logic [WIDTH-1:0] da;
        logic [WIDTH-1:0] db;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record what the response for this request must look like
    task automatic push_exp(input int r, input bit wr, input logic [DEPTH-1:0] a,
                            input logic [DEPTH-1:0] b, input logic [WIDTH-1:0] wd);
        exp_t e;
        e.r  = r;
        e.wr = wr;
        if (wr) begin
            if (a != 0) exp_mem[a] = wd;
        end else begin
            last_a = exp_mem[a];
            last_b = exp_mem[b];
        end
        e.da = last_a;
        e.db = last_b;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the response in RESP
    task automatic check_rsp(input string tag);
        exp_t e;
        logic [1:0] oh;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e  = sb.pop_front();
        oh = 2'b00;
        oh[e.r] = 1'b1;
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
        chk({tag, "_rsp_data_a"}, 64'(rsp_data_a), 64'(e.da));
        chk({tag, "_rsp_data_b"}, 64'(rsp_data_b), 64'(e.db));
    endtask

    // One isolated transaction; entered and left at a negedge in IDLE
    task automatic txn(input string tag, input int r, input bit wr,
                       input logic [DEPTH-1:0] a, input logic [DEPTH-1:0] b,
                       input logic [WIDTH-1:0] wd);
        logic [1:0] oh;
        oh = 2'b00;
        oh[r] = 1'b1;
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_idx_a[r*DEPTH +: DEPTH] = a;
        req_idx_b[r*DEPTH +: DEPTH] = b;
        req_wdata[r*WIDTH +: WIDTH] = wd;
        push_exp(r, wr, a, b, wd);
        #1;
        chk({tag, "_ready_idle"}, 64'(req_ready), 64'(oh));
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        // ACCESS cycle
        chk({tag, "_ready_access"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid_access"}, 64'(rsp_valid), 64'd0);
        if (wr) begin
            chk({tag, "_we"}, 64'(rf_write_enable), 64'(a != 0));
            chk({tag, "_widx"}, 64'(rf_write_index), 64'(a));
            chk({tag, "_wdata"}, 64'(rf_write_data), 64'(wd));
            chk({tag, "_re_on_write"}, 64'(rf_read_enable), 64'd0);
        end else begin
            chk({tag, "_re"}, 64'(rf_read_enable), 64'd1);
            chk({tag, "_ridx"}, 64'({rf_read_index_1, rf_read_index_2}), 64'({a, b}));
            chk({tag, "_we_on_read"}, 64'(rf_write_enable), 64'd0);
        end
        @(negedge clk);
        // RESP cycle
        check_rsp(tag);
        chk({tag, "_rf_idle_resp"},
            64'({rf_read_enable, rf_write_enable, rf_read_index_1, rf_write_index}), 64'd0);
        @(negedge clk);
        chk({tag, "_rsp_valid_after"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] oh;
        int g;
        for (int i = 0; i < 2**DEPTH; i++) exp_mem[i] = '0;
        last_a    = '0;
        last_b    = '0;
        reset     = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_idx_a = '0;
        req_idx_b = '0;
        req_wdata = '0;

        // Reset state, with both requesters already valid
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'({rsp_data_a, rsp_data_b}), 64'd0);
        chk("rst_rf_en", 64'({rf_read_enable, rf_write_enable}), 64'd0);
        chk("rst_rf_idx", 64'({rf_read_index_1, rf_read_index_2, rf_write_index}), 64'd0);
        chk("rst_rf_wdata", 64'(rf_write_data), 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic write and read-back
        txn("wr5", 0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF);
        txn("rd5", 1, 1'b0, 5'd5, 5'd0, 32'h0);
        // Lone requester 1 is granted even though it was granted last
        txn("wr7", 1, 1'b1, 5'd7, 5'd0, 32'hCAFEF00D);
        // Write to index 0 is suppressed but still completes
        txn("wr0", 0, 1'b1, 5'd0, 5'd0, 32'h12345678);
        txn("rd0_7", 0, 1'b0, 5'd0, 5'd7, 32'h0);
        // rsp_data must survive an intervening write
        txn("wr3", 1, 1'b1, 5'd3, 5'd0, 32'h0BADF00D);

        // Both requesters valid continuously after reset
        pulse_reset();
        req_write = 2'b00;
        req_idx_a = {5'd7, 5'd5};
        req_idx_b = {5'd5, 5'd7};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = k % 2;
`endif
            oh = 2'b00;
            oh[g] = 1'b1;
            #1;
            chk($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(oh));
            push_exp(g, 1'b0, (g == 0) ? 5'd5 : 5'd7, (g == 0) ? 5'd7 : 5'd5, 32'h0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rr%0d_ready_access", k), 64'(req_ready), 64'd0);
            @(negedge clk);
            chk($sformatf("rr%0d_ready_resp", k), 64'(req_ready), 64'd0);
            check_rsp($sformatf("rr%0d", k));
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Reset during the ACCESS cycle of a write
        req_valid = 2'b01;
        req_write = 2'b01;
        req_idx_a = {5'd0, 5'd9};
        req_wdata = {32'h0, 32'h55AA55AA};
        @(posedge clk);
        #1;
        chk("rac_we_before", 64'({rf_write_enable, rf_write_index}), 64'({1'b1, 5'd9}));
        reset  = 1'b1;
        last_a = '0;
        last_b = '0;
        #1;
        chk("rac_we_after", 64'(rf_write_enable), 64'd0);
        chk("rac_rf_zero", 64'({rf_write_index, rf_write_data}), 64'd0);
        chk("rac_ready", 64'(req_ready), 64'd0);
        chk("rac_rsp_data", 64'({rsp_data_a, rsp_data_b}), 64'd0);
        @(negedge clk);
        req_valid = 2'b00;
        chk("rac_rsp0", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("rac_rsp1", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rac_rsp2", 64'(rsp_valid), 64'd0);
        req_valid = 2'b11;
        #1;
        chk("rac_first_tie", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        @(negedge clk);
        // The dropped write must not have reached register 9
        txn("rd9", 1, 1'b0, 5'd9, 5'd5, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
